// File: rtl/accel_sched.sv
// Wishbone-mapped job sequencer: stages operands, launches one of four
// fixed-latency arithmetic units, captures its result and raises an interrupt.
module accel_sched #(
    parameter int unsigned LAT0 = 2,
    parameter int unsigned LAT1 = 4,
    parameter int unsigned LAT2 = 3,
    parameter int unsigned LAT3 = 8
) (
    input  logic        wb_clk_i,
    input  logic        wb_rst_i,
    input  logic        wbs_cyc_i,
    input  logic        wbs_stb_i,
    input  logic        wbs_we_i,
    input  logic [3:0]  wbs_sel_i,
    input  logic [31:0] wbs_adr_i,
    input  logic [31:0] wbs_dat_i,
    output logic [31:0] wbs_dat_o,
    output logic        wbs_ack_o,
    output logic        irq_o,
    output logic [1:0]  unit_sel_o,
    output logic [3:0]  unit_start_o,
    output logic [31:0] op_a_o,
    output logic [31:0] op_b_o,
    output logic [31:0] op_c_o,
    input  logic [31:0] res0_i,
    input  logic [31:0] res1_i,
    input  logic [31:0] res2_i,
    input  logic [31:0] res3_i
);

    typedef enum logic [1:0] {S_IDLE, S_LAUNCH, S_WAIT, S_CAPTURE} state_t;

    state_t      state_q, state_d;
    logic [31:0] opa_q, opb_q, opc_q, result_q;
    logic [1:0]  unit_q;
    logic        irq_en_q, done_q, err_q;
    logic [3:0]  cnt_q, lat_m1;
    logic [31:0] res_sel, rd_data;
    logic [2:0]  reg_idx;
    logic        accept, wr, busy, start_req, start_ok;
    logic        unused_adr;

    assign reg_idx    = wbs_adr_i[4:2];
    assign unused_adr = ^{wbs_adr_i[31:5], wbs_adr_i[1:0]};
    assign accept     = wbs_cyc_i & wbs_stb_i & ~wbs_ack_o;
    // Writes commit at the end of the ack cycle so LAUNCH lands one cycle after ack.
    assign wr         = wbs_ack_o & wbs_cyc_i & wbs_stb_i & wbs_we_i;
    assign busy       = (state_q != S_IDLE);
    assign start_req  = wr && (reg_idx == 3'd0) && wbs_sel_i[0] && wbs_dat_i[0];
    assign start_ok   = start_req && !busy;
    assign irq_o      = done_q & irq_en_q;

    function automatic logic [31:0] merge(input logic [31:0] old_v,
                                          input logic [31:0] new_v,
                                          input logic [3:0]  sel);
        logic [31:0] r;
        r = old_v;
        for (int unsigned i = 0; i < 4; i++)
            if (sel[i]) r[8*i +: 8] = new_v[8*i +: 8];
        return r;
    endfunction

    always_comb begin
        lat_m1  = 4'(LAT0 - 1);
        res_sel = res0_i;
        case (unit_sel_o)
            2'd1: begin lat_m1 = 4'(LAT1 - 1); res_sel = res1_i; end
            2'd2: begin lat_m1 = 4'(LAT2 - 1); res_sel = res2_i; end
            2'd3: begin lat_m1 = 4'(LAT3 - 1); res_sel = res3_i; end
            default: ;
        endcase
    end

    always_comb begin
        case (reg_idx)
            3'd0:    rd_data = {28'b0, irq_en_q, unit_q, 1'b0};
            3'd1:    rd_data = opa_q;
            3'd2:    rd_data = opb_q;
            3'd3:    rd_data = opc_q;
            3'd4:    rd_data = result_q;
            3'd5:    rd_data = {29'b0, err_q, done_q, busy};
            default: rd_data = '0;
        endcase
    end

    always_comb begin
        state_d      = state_q;
        unit_start_o = '0;
        case (state_q)
            S_IDLE:    if (start_ok) state_d = S_LAUNCH;
            S_LAUNCH: begin
                unit_start_o = 4'b0001 << unit_sel_o;
                state_d      = (lat_m1 == 4'd0) ? S_CAPTURE : S_WAIT;
            end
            S_WAIT:    if (cnt_q == 4'd1) state_d = S_CAPTURE;
            S_CAPTURE: state_d = S_IDLE;
            default:   state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            state_q    <= S_IDLE;
            wbs_ack_o  <= 1'b0;
            wbs_dat_o  <= '0;
            opa_q      <= '0;
            opb_q      <= '0;
            opc_q      <= '0;
            result_q   <= '0;
            unit_q     <= '0;
            irq_en_q   <= 1'b0;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
            cnt_q      <= '0;
            unit_sel_o <= '0;
            op_a_o     <= '0;
            op_b_o     <= '0;
            op_c_o     <= '0;
        end else begin
            state_q   <= state_d;
            wbs_ack_o <= accept;
            if (accept) wbs_dat_o <= rd_data;

            if (wr) begin
                case (reg_idx)
                    3'd0: if (wbs_sel_i[0]) begin
                        unit_q   <= wbs_dat_i[2:1];
                        irq_en_q <= wbs_dat_i[3];
                    end
                    3'd1: opa_q <= merge(opa_q, wbs_dat_i, wbs_sel_i);
                    3'd2: opb_q <= merge(opb_q, wbs_dat_i, wbs_sel_i);
                    3'd3: opc_q <= merge(opc_q, wbs_dat_i, wbs_sel_i);
                    3'd5: if (wbs_sel_i[0]) begin
                        if (wbs_dat_i[1]) done_q <= 1'b0;
                        if (wbs_dat_i[2]) err_q  <= 1'b0;
                    end
                    default: ;
                endcase
            end

            if (start_req && busy) err_q <= 1'b1;
            if (start_ok) begin
                unit_sel_o <= wbs_dat_i[2:1];
                op_a_o     <= opa_q;
                op_b_o     <= opb_q;
                op_c_o     <= opc_q;
                done_q     <= 1'b0;
            end

            case (state_q)
                S_LAUNCH:  cnt_q <= lat_m1;
                S_WAIT:    cnt_q <= cnt_q - 4'd1;
                S_CAPTURE: begin
                    result_q <= res_sel;
                    done_q   <= 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_accel_sched.sv
// Directed bench for accel_sched: register map, job timing, busy protection,
// W1C flags and mid-job reset.
module tb_accel_sched;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        cyc = 1'b0, stb = 1'b0, we = 1'b0;
    logic [3:0]  sel = '0;
    logic [31:0] adr = '0, wdat = '0;
    logic [31:0] rdat_o;
    logic        ack, irq;
    logic [1:0]  unit_sel;
    logic [3:0]  unit_start;
    logic [31:0] op_a, op_b, op_c;
    logic [31:0] res0 = '0, res1 = '0, res2 = '0, res3 = '0;

    int compared = 0;
    int mismatched = 0;
    int pulse_cnt = 0;
    int p_snap;
    logic [31:0] rd;

    always #5 clk = ~clk;

    accel_sched #(.LAT0(2), .LAT1(4), .LAT2(3), .LAT3(8)) dut (
        .wb_clk_i(clk), .wb_rst_i(rst),
        .wbs_cyc_i(cyc), .wbs_stb_i(stb), .wbs_we_i(we),
        .wbs_sel_i(sel), .wbs_adr_i(adr), .wbs_dat_i(wdat),
        .wbs_dat_o(rdat_o), .wbs_ack_o(ack), .irq_o(irq),
        .unit_sel_o(unit_sel), .unit_start_o(unit_start),
        .op_a_o(op_a), .op_b_o(op_b), .op_c_o(op_c),
        .res0_i(res0), .res1_i(res1), .res2_i(res2), .res3_i(res3)
    );

    always @(negedge clk) if (unit_start != 4'b0) pulse_cnt++;

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic wb_wait_ack(input string tag);
        bit got = 0;
        for (int i = 0; i < 20 && !got; i++) begin
            step(1);
            if (ack) got = 1;
        end
        chk(tag, {31'b0, ack}, 32'd1);
    endtask

    // Returns in the cycle after the ack cycle (the write has committed).
    task automatic wb_write(input int idx, input logic [31:0] data, input logic [3:0] be);
        cyc = 1; stb = 1; we = 1; sel = be; wdat = data;
        adr = 32'(idx) << 2;
        wb_wait_ack($sformatf("wr_ack_%0d", idx));
        step(1);
        cyc = 0; stb = 0; we = 0;
    endtask

    // Returns the register value as it was in the call cycle.
    task automatic wb_read(input int idx, output logic [31:0] data);
        cyc = 1; stb = 1; we = 0; sel = 4'hF;
        adr = 32'(idx) << 2;
        wb_wait_ack($sformatf("rd_ack_%0d", idx));
        data = rdat_o;
        cyc = 0; stb = 0;
        step(1);
    endtask

    initial begin
        step(3);
        rst = 0;

        // Reset state
        chk("rst_ack", {31'b0, ack}, 32'd0);
        chk("rst_dat", rdat_o, 32'd0);
        chk("rst_irq", {31'b0, irq}, 32'd0);
        chk("rst_unit_sel", {30'b0, unit_sel}, 32'd0);
        chk("rst_start", {28'b0, unit_start}, 32'd0);
        chk("rst_op_a", op_a, 32'd0);
        for (int i = 0; i < 6; i++) begin
            wb_read(i, rd);
            chk($sformatf("rst_reg%0d", i), rd, 32'd0);
        end

        // Unused addresses ignore writes and read 0; byte lanes honoured
        wb_write(6, 32'hFFFFFFFF, 4'hF);
        wb_read(6, rd); chk("adr6", rd, 32'd0);
        wb_read(7, rd); chk("adr7", rd, 32'd0);
        wb_write(3, 32'hAABBCCDD, 4'b0101);
        wb_read(3, rd); chk("opc_lanes", rd, 32'h00BB00DD);

        // Job on unit 0, LAT0=2
        wb_write(1, 32'h00001234, 4'hF);
        wb_write(2, 32'h00000001, 4'hF);
        wb_write(0, 32'h1, 4'hF);                // now at T+1
        chk("j0_start", {28'b0, unit_start}, 32'b0001);
        chk("j0_op_a", op_a, 32'h00001234);
        chk("j0_op_b", op_b, 32'h00000001);
        chk("j0_op_c", op_c, 32'h00BB00DD);
        res0 = 32'hDEAD0000;
        step(1);                                 // T+2
        chk("j0_start_off", {28'b0, unit_start}, 32'd0);
        step(1);                                 // T+3: sampled at end of this cycle
        res0 = 32'h00001235;
        step(1);                                 // T+4
        wb_read(4, rd); chk("j0_result", rd, 32'h00001235);
        wb_read(5, rd); chk("j0_status", rd, 32'h2);
        chk("j0_irq", {31'b0, irq}, 32'd0);

        // Job on unit 3 with irq_en, LAT3=8
        res3 = 32'hCAFE0003;
        wb_write(0, 32'hF, 4'hF);                // T+1
        chk("j3_start", {28'b0, unit_start}, 32'b1000);
        chk("j3_unit_sel", {30'b0, unit_sel}, 32'd3);
        wb_read(5, rd); chk("j3_busy_t1", rd, 32'h1);   // value at T+1
        step(6);                                 // T+9
        chk("j3_irq_t9", {31'b0, irq}, 32'd0);
        wb_read(5, rd); chk("j3_busy_t9", rd, 32'h1);   // value at T+9
        chk("j3_irq_t11", {31'b0, irq}, 32'd1);
        wb_read(5, rd); chk("j3_status", rd, 32'h2);
        wb_read(4, rd); chk("j3_result", rd, 32'hCAFE0003);
        wb_read(0, rd); chk("j3_ctrl", rd, 32'hE);
        wb_write(5, 32'h2, 4'hF);
        chk("j3_irq_clr", {31'b0, irq}, 32'd0);
        wb_read(5, rd); chk("j3_status_clr", rd, 32'h0);

        // Unit 1 job, second START while busy, staging write while busy
        res1 = 32'h11110001;
        wb_write(2, 32'h0, 4'hF);
        p_snap = pulse_cnt;
        wb_write(0, 32'h3, 4'hF);                // T+1
        chk("j1_start", {28'b0, unit_start}, 32'b0010);
        wb_write(0, 32'h5, 4'hF);                // commits in WAIT, returns T+3
        wb_write(2, 32'hFFFFFFFF, 4'b0010);      // returns T+5
        chk("j1_op_b_stable", op_b, 32'd0);
        step(1);
        wb_read(5, rd); chk("j1_status_err", rd, 32'h6);
        wb_read(4, rd); chk("j1_result", rd, 32'h11110001);
        chk("j1_unit_sel", {30'b0, unit_sel}, 32'd1);
        chk("j1_pulses", 32'(pulse_cnt - p_snap), 32'd1);
        wb_read(0, rd); chk("j1_ctrl", rd, 32'h4);
        wb_read(2, rd); chk("j1_opb_lane", rd, 32'h0000FF00);
        wb_write(5, 32'h4, 4'hF);
        wb_read(5, rd); chk("j1_err_clr", rd, 32'h2);

        // Reset during WAIT of unit 2
        res2 = 32'h22220002;
        wb_write(0, 32'h5, 4'hF);                // T+1
        chk("j2_start", {28'b0, unit_start}, 32'b0100);
        step(1);                                 // T+2, WAIT
        rst = 1;
        step(1);                                 // T+3
        rst = 0;
        p_snap = pulse_cnt;
        chk("j2_rst_start", {28'b0, unit_start}, 32'd0);
        chk("j2_rst_op_a", op_a, 32'd0);
        chk("j2_rst_unit_sel", {30'b0, unit_sel}, 32'd0);
        wb_read(5, rd); chk("j2_rst_status", rd, 32'h0);
        step(4);
        chk("j2_no_pulse", 32'(pulse_cnt - p_snap), 32'd0);
        wb_read(4, rd); chk("j2_rst_result", rd, 32'h0);
        wb_read(5, rd); chk("j2_rst_status2", rd, 32'h0);
        chk("j2_rst_irq", {31'b0, irq}, 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
